// File: rtl/qos_pkg.sv
// Shared QoS definitions: band encodings, QoS-to-band mapping and the demoted QoS value.
// Used by the ingress shaper and by the wrapper's write-routing logic.
package qos_pkg;

    typedef enum logic [2:0] {
        BAND_BE   = 3'd0,
        BAND_1    = 3'd1,
        BAND_2    = 3'd2,
        BAND_3    = 3'd3,
        BAND_HIBW = 3'd4
    } band_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_PEND  = 1'b1
    } shp_state_e;

    localparam logic [3:0] QOS_DEMOTED = 4'b0000;

    // High-bandwidth flag overrides the band field.
    function automatic band_e qos_to_band(input logic [3:0] qos);
        if (qos[3]) return BAND_HIBW;
        return band_e'({1'b0, qos[2:1]});
    endfunction

    function automatic logic is_shaped(input band_e band);
        return (band == BAND_1) || (band == BAND_2) || (band == BAND_3);
    endfunction

endpackage

// File: rtl/qos_token_bucket.sv
// One shaped band's credit counter: saturating refill, consume, and a nonzero flag.
// A refill and a consume on the same edge cancel out.
module qos_token_bucket #(
    parameter int BURST = 4
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iRefill,
    input  logic iConsume,
    output logic oNonZero
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] FULL = CW'(BURST);

    logic [CW-1:0] r_credit;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_credit <= FULL;
        end else if (iRefill && !iConsume) begin
            if (r_credit != FULL) r_credit <= r_credit + CW'(1);
        end else if (iConsume && !iRefill) begin
            if (r_credit != '0) r_credit <= r_credit - CW'(1);
        end
    end

    assign oNonZero = (r_credit != '0);

endmodule

// File: rtl/qos_ingress_shaper.sv
// Ingress shaper: one-entry holding register, per-band token buckets for bands 1-3,
// and paced single-cycle write pulses toward the QoS FIFO wrapper.
module qos_ingress_shaper #(
    parameter int DSIZE         = 32,
    parameter int BURST         = 4,
    parameter int REFILL_PERIOD = 8,
    parameter int WR_GAP        = 2,
    parameter int DEMOTE        = 1
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iValid,
    output logic             oReady,
    input  logic [DSIZE-1:0] iData,
    input  logic [3:0]       iQoS,
    input  logic             iFull,
    output logic             oWr,
    output logic [DSIZE-1:0] oWrData,
    output logic [3:0]       oQoS,
    output logic             oDemote
);
    import qos_pkg::*;

    localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    shp_state_e       r_state, w_next_state;
    logic [DSIZE-1:0] r_data;
    logic [3:0]       r_qos;
    logic [GW-1:0]    r_gap;
    logic [RW-1:0]    r_refill;
    logic             r_wr, r_demote;
    logic [DSIZE-1:0] r_wr_data;
    logic [3:0]       r_wr_qos;

    band_e      w_band;
    logic       w_shaped, w_has_credit, w_refill_tick;
    logic       w_accept, w_issue, w_demote_now, w_consume;
    logic [2:0] w_nz, w_consume_vec;

    assign w_band        = qos_to_band(r_qos);
    assign w_shaped      = is_shaped(w_band);
    assign w_refill_tick = (r_refill == RW'(REFILL_PERIOD - 1));

    // Shared refill timer; every shaped band refills on the same wrap.
    always_ff @(posedge iClk) begin
        if (iReset) r_refill <= '0;
        else        r_refill <= w_refill_tick ? '0 : r_refill + RW'(1);
    end

    for (genvar b = 0; b < 3; b++) begin : g_band
        qos_token_bucket #(.BURST(BURST)) u_bucket (
            .iClk     (iClk),
            .iReset   (iReset),
            .iRefill  (w_refill_tick),
            .iConsume (w_consume_vec[b]),
            .oNonZero (w_nz[b])
        );
    end

    always_ff @(posedge iClk) begin
        if (iReset) r_state <= ST_EMPTY;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_PEND;
            ST_PEND:  if (w_issue)  w_next_state = ST_EMPTY;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    always_comb begin
        oReady        = (r_state == ST_EMPTY) && !iReset;
        w_accept      = iValid && oReady;
        w_issue       = 1'b0;
        w_demote_now  = 1'b0;
        w_consume     = 1'b0;
        w_consume_vec = '0;
        case (w_band)
            BAND_1:  w_has_credit = w_nz[0];
            BAND_2:  w_has_credit = w_nz[1];
            BAND_3:  w_has_credit = w_nz[2];
            default: w_has_credit = 1'b1;
        endcase
        if (r_state == ST_PEND && !iFull && r_gap == '0) begin
            if (!w_shaped || w_has_credit) begin
                w_issue   = 1'b1;
                w_consume = w_shaped;
            end else if (DEMOTE != 0) begin
                // Out of credit: send as best effort without touching the bucket.
                w_issue      = 1'b1;
                w_demote_now = 1'b1;
            end
        end
        w_consume_vec[0] = w_consume && (w_band == BAND_1);
        w_consume_vec[1] = w_consume && (w_band == BAND_2);
        w_consume_vec[2] = w_consume && (w_band == BAND_3);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_data    <= '0;
            r_qos     <= '0;
            r_gap     <= '0;
            r_wr      <= 1'b0;
            r_demote  <= 1'b0;
            r_wr_data <= '0;
            r_wr_qos  <= '0;
        end else begin
            if (w_accept) begin
                r_data <= iData;
                r_qos  <= iQoS;
            end
            // Gap covers the wrapper's registered full flag lagging our writes.
            if (w_issue)            r_gap <= GW'(WR_GAP);
            else if (r_gap != '0)   r_gap <= r_gap - GW'(1);
            r_wr      <= w_issue;
            r_demote  <= w_demote_now;
            r_wr_data <= w_issue ? r_data : '0;
            r_wr_qos  <= w_issue ? (w_demote_now ? QOS_DEMOTED : r_qos) : '0;
        end
    end

    assign oWr     = r_wr;
    assign oWrData = r_wr_data;
    assign oQoS    = r_wr_qos;
    assign oDemote = r_demote;

endmodule

// File: tb/tb_qos_ingress_shaper.sv
// Scoreboard bench for qos_ingress_shaper: one instance with demotion, one with stalling.
// Expected writes are queued at accept and checked against a credit model when they appear.
module tb_qos_ingress_shaper;
    logic clk = 1'b0;
    logic rst = 1'b1, valid = 1'b0, full = 1'b0, sel = 1'b1;
    logic [31:0] data = '0;
    logic [3:0]  qos = '0;
    logic rdy0, rdy1, wr0, wr1, dem0, dem1;
    logic [31:0] wd0, wd1;
    logic [3:0]  wq0, wq1;

    always #5 clk = ~clk;

    qos_ingress_shaper #(.DSIZE(32), .BURST(4), .REFILL_PERIOD(8), .WR_GAP(2), .DEMOTE(1)) dut1 (
        .iClk(clk), .iReset(rst), .iValid(valid && sel), .oReady(rdy1), .iData(data), .iQoS(qos),
        .iFull(full), .oWr(wr1), .oWrData(wd1), .oQoS(wq1), .oDemote(dem1));

    qos_ingress_shaper #(.DSIZE(32), .BURST(4), .REFILL_PERIOD(8), .WR_GAP(2), .DEMOTE(0)) dut0 (
        .iClk(clk), .iReset(rst), .iValid(valid && !sel), .oReady(rdy0), .iData(data), .iQoS(qos),
        .iFull(full), .oWr(wr0), .oWrData(wd0), .oQoS(wq0), .oDemote(dem0));

    wire        w_rdy = sel ? rdy1 : rdy0;
    wire        w_wr  = sel ? wr1 : wr0;
    wire        w_dem = sel ? dem1 : dem0;
    wire [31:0] w_wd  = sel ? wd1 : wd0;
    wire [3:0]  w_wq  = sel ? wq1 : wq0;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    logic rst_seen = 1'b1;
    logic [35:0] sbq[$];
    int wr_cyc[$];
    int ndem = 0;
    logic [31:0] dem_mask = '0;
    int m_cred[4] = '{4, 4, 4, 4};

    // Edge number since reset release: edge k has cyc==k when sampled after it.
    always @(posedge clk) begin
        cyc      <= rst ? 0 : cyc + 1;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        logic [35:0] e;
        logic [3:0]  xq;
        logic        cons, nocred, xdem;
        int          b;
        cons = 1'b0;
        b = 0;
        n_cmp++;
        if ((sel ? wr0 : wr1) !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_instance_wr: unselected instance wrote at cycle %0d", cyc);
        end
        if (w_wr === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_wr: write at cycle %0d data %h, nothing expected", cyc, w_wd);
            end else begin
                e = sbq.pop_front();
                b = e[35] ? 4 : int'(e[34:33]);
                nocred = (b >= 1 && b <= 3 && m_cred[b] == 0);
                xdem = nocred && sel;
                cons = (b >= 1 && b <= 3 && !nocred);
                xq = xdem ? 4'b0000 : e[35:32];
                if (w_wd !== e[31:0] || w_wq !== xq || w_dem !== xdem) begin
                    n_bad++;
                    $display("FAIL wr_content: cycle %0d got data %h qos %b dem %b, want %h %b %b",
                             cyc, w_wd, w_wq, w_dem, e[31:0], xq, xdem);
                end
                if (nocred && !sel) begin
                    n_cmp++; n_bad++;
                    $display("FAIL no_credit_issue: stall instance wrote band %0d with 0 credit", b);
                end
                if (wr_cyc.size() > 0) begin
                    n_cmp++;
                    if (cyc - wr_cyc[$] < 3) begin
                        n_bad++;
                        $display("FAIL wr_spacing: got %0d cycles, want >= 3", cyc - wr_cyc[$]);
                    end
                end
                if (w_dem === 1'b1) begin
                    dem_mask[wr_cyc.size()] = 1'b1;
                    ndem++;
                end
                wr_cyc.push_back(cyc);
            end
        end else begin
            n_cmp++;
            if (w_wd !== 32'h0 || w_wq !== 4'h0 || w_dem !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_outputs: cycle %0d got data %h qos %b dem %b, want zeros",
                         cyc, w_wd, w_wq, w_dem);
            end
        end
        if (rst_seen) begin
            for (int k = 1; k <= 3; k++) m_cred[k] = 4;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                if (cyc % 8 == 0 && !(cons && k == b)) begin
                    if (m_cred[k] < 4) m_cred[k] = m_cred[k] + 1;
                end else if (cyc % 8 != 0 && cons && k == b) begin
                    m_cred[k] = m_cred[k] - 1;
                end
            end
        end
    end

    task automatic do_reset(input logic s);
        rst = 1'b1; valid = 1'b0; full = 1'b0; sel = s;
        sbq.delete(); wr_cyc.delete(); ndem = 0; dem_mask = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] q, output int acc);
        logic r;
        acc = -1;
        valid = 1'b1; data = d; qos = q;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); r = w_rdy;
            @(posedge clk); #1;
            if (r) begin acc = cyc; break; end
        end
        valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drive_timeout: data %h never accepted", d);
        end else begin
            sbq.push_back({q, d});
        end
    endtask

    task automatic drain();
        int i = 0;
        while (sbq.size() != 0 && i < 300) begin @(posedge clk); #1; i++; end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d writes outstanding, want 0", sbq.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b1; valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b%b, want 00", rdy1, rdy0);
        end
        n_cmp++;
        if ({wr1, wd1, wq1, dem1, wr0, wd0, wq0, dem0} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got wr %b%b data %h %h, want zero", wr1, wr0, wd1, wd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b%b, want 11", rdy1, rdy0);
        end
    endtask

    task automatic test_single();
        int acc;
        do_reset(1'b1);
        drive(32'hA5A5_A5A5, 4'b0010, acc);
        drain();
        n_cmp++;
        if (acc != 1) begin n_bad++; $display("FAIL single_accept: got edge %0d, want 1", acc); end
        n_cmp++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != 2) begin
            n_bad++; $display("FAIL single_latency: got %0d writes first at %0d, want 1 at 2",
                              wr_cyc.size(), wr_cyc.size() ? wr_cyc[0] : -1);
        end
    endtask

    task automatic test_demote();
        int acc;
        logic ok = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) drive(32'h1000_0000 + i, 4'b0011, acc);
        drain();
        n_cmp++;
        if (wr_cyc.size() != 10 || dem_mask !== 32'h0000_02C0) begin
            n_bad++; $display("FAIL demote_pattern: got %0d writes mask %h, want 10 mask 000002c0",
                              wr_cyc.size(), dem_mask);
        end
        for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 3) ok = 1'b0;
        n_cmp++;
        if (!ok || wr_cyc.size() == 0 || wr_cyc[0] != 2) begin
            n_bad++; $display("FAIL back_to_back_spacing: writes not every 3 cycles from edge 2");
        end
    endtask

    task automatic test_stall();
        int acc;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) drive(32'h2000_0000 + i, 4'b0011, acc);
        drain();
        n_cmp++;
        if (acc != 26) begin n_bad++; $display("FAIL stall_ready: 8th accept at %0d, want 26", acc); end
        n_cmp++;
        if (wr_cyc.size() != 8 || wr_cyc[6] != 25 || wr_cyc[7] != 33 || ndem != 0) begin
            n_bad++; $display("FAIL stall_issue: got %0d writes, 7th/8th at %0d/%0d dem %0d, want 8 at 25/33 dem 0",
                              wr_cyc.size(), wr_cyc.size() > 6 ? wr_cyc[6] : -1,
                              wr_cyc.size() > 7 ? wr_cyc[7] : -1, ndem);
        end
    endtask

    task automatic test_full();
        int acc, acc2;
        do_reset(1'b1);
        full = 1'b1;
        drive(32'h1111_2222, 4'b0000, acc);
        repeat (9) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_cyc.size() != 0) begin
            n_bad++; $display("FAIL full_hold: got %0d writes while full, want 0", wr_cyc.size());
        end
        full = 1'b0;
        drive(32'h3333_4444, 4'b1000, acc2);
        drain();
        n_cmp++;
        if (acc2 != 12 || wr_cyc.size() != 2 || wr_cyc[0] != 11 || wr_cyc[1] != 14) begin
            n_bad++; $display("FAIL full_release: accept %0d writes %0d, want accept 12 writes at 11,14",
                              acc2, wr_cyc.size());
        end
    endtask

    task automatic test_unshaped();
        int acc;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) drive(32'h4000_0000 + i, 4'b1010, acc);
        for (int i = 0; i < 2; i++) drive(32'h5000_0000 + i, 4'b0001, acc);
        for (int i = 0; i < 5; i++) drive(32'h6000_0000 + i, 4'b0011, acc);
        drain();
        n_cmp++;
        if (wr_cyc.size() != 11 || ndem != 0) begin
            n_bad++; $display("FAIL unshaped: got %0d writes %0d demoted, want 11 and 0", wr_cyc.size(), ndem);
        end
    endtask

    task automatic test_same_edge();
        int acc, first;
        do_reset(1'b1);
        repeat (6) @(posedge clk);
        #1;
        drive(32'h7000_0000, 4'b0100, first);
        for (int i = 1; i < 6; i++) drive(32'h7000_0000 + i, 4'b0100, acc);
        drain();
        n_cmp++;
        if (first != 7 || wr_cyc.size() != 6 || wr_cyc[0] != 8 || ndem != 0) begin
            n_bad++; $display("FAIL refill_consume_same_edge: accept %0d writes %0d demoted %0d, want 7, 6, 0",
                              first, wr_cyc.size(), ndem);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) drive(32'h8000_0000 + i, 4'b0010, acc);
        drain();
        full = 1'b1;
        drive(32'hDEAD_BEEF, 4'b0010, acc);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ready: got %b, want 0", rdy1); end
        do_reset(1'b1);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_cyc.size() != 0) begin
            n_bad++; $display("FAIL reset_mid_drop: got %0d writes after reset, want 0", wr_cyc.size());
        end
        for (int i = 0; i < 5; i++) drive(32'h9000_0000 + i, 4'b0010, acc);
        drain();
        n_cmp++;
        if (wr_cyc.size() != 5 || ndem != 0) begin
            n_bad++; $display("FAIL reset_mid_credits: got %0d writes %0d demoted, want 5 and 0", wr_cyc.size(), ndem);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_demote();
        test_stall();
        test_full();
        test_unshaped();
        test_same_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
